// File: rtl/mem_arbiter.sv
// mem_arbiter: buffers a two-slot load/store pair and issues it in order to a
// single-outstanding data memory, returning one response pulse per slot.
module mem_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [1:0]             in_valid,
    input  logic [1:0]             in_we,
    input  logic [1:0][1:0]        in_size,
    input  logic [1:0][DATA_W-1:0] in_addr,
    input  logic [1:0][DATA_W-1:0] in_wdata,
    output logic                   in_ready,
    output logic                   stall,
    input  logic                   flush,
    output logic                   dm_req,
    output logic                   dm_we,
    output logic [1:0]             dm_size,
    output logic [DATA_W-1:0]      dm_addr,
    output logic [DATA_W-1:0]      dm_wdata,
    input  logic                   dm_addr_ok,
    input  logic                   dm_data_ok,
    input  logic [DATA_W-1:0]      dm_rdata,
    output logic [1:0]             resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   pair_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              pend, pend_nxt;
    logic                    cur, cur_nxt;
    logic                    capture;
    logic                    sel;
    logic [1:0]              buf_we;
    logic [1:0][1:0]         buf_size;
    logic [1:0][DATA_W-1:0]  buf_addr, buf_wdata;

    // While issuing, the slot is picked from pend; once issued it is held in cur.
    assign sel = (state == ISSUE) ? ~pend[0] : cur;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            pend  <= '0;
            cur   <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            cur   <= cur_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            buf_we    <= in_we;
            buf_size  <= in_size;
            buf_addr  <= in_addr;
            buf_wdata <= in_wdata;
        end
    end

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        cur_nxt    = cur;
        capture    = 1'b0;
        in_ready   = 1'b0;
        dm_req     = 1'b0;
        resp_valid = 2'b00;
        pair_done  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (|in_valid && !flush) begin
                    capture   = 1'b1;
                    pend_nxt  = in_valid;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                dm_req = 1'b1;
                if (dm_addr_ok) begin
                    cur_nxt   = sel;
                    pend_nxt  = flush ? 2'b00 : (pend & {~sel, sel});
                    state_nxt = WAIT_DATA;
                end else if (flush) begin
                    pend_nxt  = 2'b00;
                    state_nxt = IDLE;
                end
            end
            WAIT_DATA: begin
                if (flush) pend_nxt = 2'b00;
                if (dm_data_ok) begin
                    resp_valid = {cur, ~cur};
                    pair_done  = (pend_nxt == 2'b00);
                    state_nxt  = (pend_nxt == 2'b00) ? IDLE : ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall      = ~in_ready;
    assign dm_we      = dm_req ? buf_we[sel] : 1'b0;
    assign dm_size    = dm_req ? buf_size[sel] : 2'b00;
    assign dm_addr    = dm_req ? buf_addr[sel] : '0;
    assign dm_wdata   = dm_req ? buf_wdata[sel] : '0;
    assign resp_rdata = (|resp_valid && !buf_we[cur]) ? dm_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven cycle vectors for mem_arbiter plus a hand-written
// asynchronous reset sequence.
module tb_mem_arbiter;
    localparam int W = 32;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  flush = 1'b0;
    logic                  dm_addr_ok = 1'b0;
    logic                  dm_data_ok = 1'b0;
    logic [1:0]            in_valid = 2'b00;
    logic [1:0]            in_we = 2'b00;
    logic [1:0][1:0]       in_size;
    logic [1:0][W-1:0]     in_addr;
    logic [1:0][W-1:0]     in_wdata;
    logic [W-1:0]          dm_rdata = '0;
    logic                  in_ready, stall, dm_req, dm_we, pair_done;
    logic [1:0]            dm_size, resp_valid;
    logic [W-1:0]          dm_addr, dm_wdata, resp_rdata;
    int                    checks = 0;
    int                    errors = 0;

    typedef struct {
        logic [1:0]   v;
        logic [1:0]   we;
        logic [W-1:0] a0;
        logic         fl;
        logic         aok;
        logic         dok;
        logic [W-1:0] rd;
        logic         rdy;
        logic         req;
        logic         ewe;
        logic [W-1:0] addr;
        logic [W-1:0] wd;
        logic [1:0]   rv;
        logic [W-1:0] rdat;
        logic         pd;
    } vec_t;

    vec_t vecs[$];

    mem_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_we(in_we),
        .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_ready(in_ready), .stall(stall), .flush(flush), .dm_req(dm_req),
        .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_addr_ok(dm_addr_ok), .dm_data_ok(dm_data_ok), .dm_rdata(dm_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .pair_done(pair_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        in_size  = {2'd2, 2'd2};
        in_addr  = {32'h20, 32'h0};
        in_wdata = {32'h22222222, 32'h11111111};
        //            v     we    a0      fl  aok dok rd              rdy req we  addr    wd             rv    rdat            pd
        vecs.push_back('{2'b01,2'b00,32'h100,1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h100,1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,1'b0,32'h100,32'h11111111,2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h100,1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h100,1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,1'b0,1'b0,32'h0,  32'h0,       2'b01,32'hDEADBEEF,1'b1});
        vecs.push_back('{2'b00,2'b00,32'h100,1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b11,2'b01,32'h10, 1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{2'b00,2'b00,32'h10,1'b0,1'b0,1'b0,32'h0,    1'b0,1'b1,1'b1,32'h10, 32'h11111111,2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,1'b1,32'h10, 32'h11111111,2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b1,32'h55,      1'b0,1'b0,1'b0,32'h0,  32'h0,       2'b01,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,1'b0,32'h20, 32'h22222222,2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b1,32'h1234,    1'b0,1'b0,1'b0,32'h0,  32'h0,       2'b10,32'h1234,    1'b1});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b10,2'b00,32'h10, 1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,1'b0,32'h20, 32'h22222222,2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b1,32'h77,      1'b0,1'b0,1'b0,32'h0,  32'h0,       2'b10,32'h77,      1'b1});
        vecs.push_back('{2'b01,2'b00,32'h40, 1'b0,1'b0,1'b1,32'h99,      1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h40, 1'b0,1'b1,1'b1,32'h88,      1'b0,1'b1,1'b0,32'h40, 32'h11111111,2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h40, 1'b0,1'b0,1'b1,32'h66,      1'b0,1'b0,1'b0,32'h0,  32'h0,       2'b01,32'h66,      1'b1});
        vecs.push_back('{2'b11,2'b00,32'h10, 1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b1,1'b0,1'b0,32'h0,       1'b0,1'b1,1'b0,32'h10, 32'h11111111,2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b1,32'h5,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b11,2'b00,32'h10, 1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,1'b0,32'h10, 32'h11111111,2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b1,32'hAB,      1'b0,1'b0,1'b0,32'h0,  32'h0,       2'b01,32'hAB,      1'b1});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b11,2'b00,32'h10, 1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b1,1'b1,1'b0,32'h0,       1'b0,1'b1,1'b0,32'h10, 32'h11111111,2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b1,32'hCD,      1'b0,1'b0,1'b0,32'h0,  32'h0,       2'b01,32'hCD,      1'b1});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b11,2'b00,32'h10, 1'b1,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});
        vecs.push_back('{2'b00,2'b00,32'h10, 1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  32'h0,       2'b00,32'h0,       1'b0});

        #12;
        chk("reset in_ready", in_ready, 1);
        chk("reset stall", stall, 0);
        chk("reset dm_req", dm_req, 0);
        chk("reset dm_addr", dm_addr, 0);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset pair_done", pair_done, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid   = vecs[i].v;
            in_we      = vecs[i].we;
            in_addr[0] = vecs[i].a0;
            flush      = vecs[i].fl;
            dm_addr_ok = vecs[i].aok;
            dm_data_ok = vecs[i].dok;
            dm_rdata   = vecs[i].rd;
            #1;
            chk($sformatf("row%0d in_ready", i), in_ready, vecs[i].rdy);
            chk($sformatf("row%0d stall", i), stall, !vecs[i].rdy);
            chk($sformatf("row%0d dm_req", i), dm_req, vecs[i].req);
            chk($sformatf("row%0d dm_we", i), dm_we, vecs[i].ewe);
            chk($sformatf("row%0d dm_size", i), dm_size, vecs[i].req ? 2 : 0);
            chk($sformatf("row%0d dm_addr", i), dm_addr, vecs[i].addr);
            chk($sformatf("row%0d dm_wdata", i), dm_wdata, vecs[i].wd);
            chk($sformatf("row%0d resp_valid", i), resp_valid, vecs[i].rv);
            chk($sformatf("row%0d resp_rdata", i), resp_rdata, vecs[i].rdat);
            chk($sformatf("row%0d pair_done", i), pair_done, vecs[i].pd);
        end

        // asynchronous reset while waiting for data, then a stray data_ok
        @(negedge clk);
        in_valid = 2'b01; in_addr[0] = 32'h100; flush = 1'b0; dm_addr_ok = 1'b0; dm_data_ok = 1'b0;
        @(negedge clk);
        in_valid = 2'b00; dm_addr_ok = 1'b1;
        #1 chk("arst issue dm_req", dm_req, 1);
        @(negedge clk);
        dm_addr_ok = 1'b0;
        #1 chk("arst wait in_ready", in_ready, 0);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst in_ready", in_ready, 1);
        chk("arst stall", stall, 0);
        chk("arst dm_req", dm_req, 0);
        chk("arst dm_addr", dm_addr, 0);
        @(negedge clk);
        resetn = 1'b1; dm_data_ok = 1'b1; dm_rdata = 32'hBAD;
        #1;
        chk("arst late resp_valid", resp_valid, 0);
        chk("arst late pair_done", pair_done, 0);
        chk("arst late in_ready", in_ready, 1);
        @(negedge clk);
        dm_data_ok = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data and address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  2  per-slot memory request from FU0/FU1; slot 0 is older in program order.
REQ-005 in_we  input  2  per-slot write enable (1 = store, 0 = load).
REQ-006 in_size  input  2x2  per-slot access size: 0 = byte, 1 = half, 2 = word.
REQ-007 in_addr / in_wdata  input  2xDATA_W each  per-slot address / store data.
REQ-008 in_ready  output  1  arbiter can accept a new request pair this cycle.
REQ-009 stall  output  1  execute-stage hold; equals ~in_ready.
REQ-010 flush  input  1  discard buffered requests not yet issued.
REQ-011 dm_req  output  1  data-memory request strobe.
REQ-012 dm_we, dm_size, dm_addr, dm_wdata  output  1, 2, DATA_W, DATA_W  fields of the current request.
REQ-013 dm_addr_ok  input  1  memory accepted the request in this cycle.
REQ-014 dm_data_ok  input  1  memory completed the outstanding request; dm_rdata valid.
REQ-015 dm_rdata  input  DATA_W  load data.
REQ-016 resp_valid  output  2  one-cycle pulse per slot on completion.
REQ-017 resp_rdata  output  DATA_W  load data for the completing slot; 0 for stores.
REQ-018 pair_done  output  1  one-cycle pulse when the last buffered request completes.

Function
REQ-019 States: IDLE, ISSUE, WAIT_DATA; in_ready = 1 only in IDLE.
REQ-020 IDLE: if in_valid != 0 and flush = 0, latch all slot fields into a 2-entry buffer with pend[1:0] = in_valid and go to ISSUE next cycle; in_valid = 0 keeps state IDLE.
REQ-021 Issue order: lowest-index pending slot first (cur = 0 if pend[0], else 1); never reorder.
REQ-022 ISSUE: dm_req = 1 with buffered fields of slot cur; fields stay stable until dm_addr_ok.
REQ-023 ISSUE with dm_addr_ok = 1: clear pend[cur]; dm_req drops the next cycle; go to WAIT_DATA.
REQ-024 Only one outstanding memory transaction; dm_req = 0 in WAIT_DATA.
REQ-025 WAIT_DATA with dm_data_ok = 1: resp_valid[cur] = 1 and resp_rdata = dm_rdata (0 if store) in that same cycle (combinational pass-through, zero latency).
REQ-026 After dm_data_ok: any pend bit set -> ISSUE; none -> IDLE with pair_done = 1 in the dm_data_ok cycle.
REQ-027 dm_addr_ok and dm_data_ok in the same cycle in ISSUE: data_ok belongs to no transaction and is ignored; addr_ok is honoured.
REQ-028 dm_data_ok outside WAIT_DATA is ignored.
REQ-029 Minimum per-request latency: 2 cycles (ISSUE with addr_ok, WAIT_DATA with data_ok); two-slot pair minimum 4 cycles plus 1 IDLE accept cycle.
REQ-030 flush in IDLE: no capture. flush in ISSUE before addr_ok: clear pend, dm_req = 0 next cycle, go IDLE, no resp_valid, no pair_done. flush in ISSUE together with addr_ok: request counts as issued; clear remaining pend, go to WAIT_DATA.
REQ-031 flush in WAIT_DATA: clear remaining pend; still wait for dm_data_ok, then pulse resp_valid[cur] and go IDLE with pair_done = 1.
REQ-032 Misaligned access (half with addr[0] = 1, word with addr[1:0] != 0) is forwarded unchanged; exception detection is not done here.

Reset
REQ-033 resetn = 0 forces state IDLE, pend = 0, cur = 0 immediately, whatever the clock.
REQ-034 Output values in reset: in_ready = 1, stall = 0, dm_req = 0, resp_valid = 0, pair_done = 0, dm_* fields = 0.
REQ-035 Reset asserted mid-transaction abandons it; a later dm_data_ok is ignored because state is IDLE.

Verification
REQ-036 Single load slot 0, addr 0x100, addr_ok at first ISSUE cycle, data_ok 2 cycles later with 0xDEADBEEF -> resp_valid = 01, resp_rdata = 0xDEADBEEF, pair_done in the same cycle, in_ready = 1 the next cycle.
REQ-037 Both slots valid (store 0x10 then load 0x20), addr_ok held 0 for 3 cycles -> dm_addr stays 0x10 and stable; slot 0 completes before slot 1 is issued; resp_valid 01 then 10; single pair_done.
REQ-038 Only slot 1 valid -> first issue is slot 1; resp_valid = 10.
REQ-039 flush during ISSUE of slot 0 without addr_ok, both pending -> dm_req = 0 next cycle, IDLE, no resp_valid, no pair_done.
REQ-040 flush during WAIT_DATA of slot 0, slot 1 pending -> slot 1 never issued; resp_valid = 01 on data_ok; IDLE follows.
REQ-041 resetn pulsed low asynchronously during WAIT_DATA -> outputs at reset values before the next clock edge; a following data_ok produces no resp_valid.
